// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter between N core-side requesters and the single system bus port.
// Grants lock for a whole burst, client ID is stamped into the tag, responses route back by tag ID.
module sysbus_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int TAG_WIDTH       = 13,
  parameter int N_CLIENTS       = 4,
  parameter int ID_WIDTH        = 2,
  parameter int RESP_BEATS      = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0] c_req,
  input  logic [N_CLIENTS*TAG_WIDTH-1:0]  c_reqtag,
  input  logic [N_CLIENTS-1:0]            c_reqcyc,
  output logic [N_CLIENTS-1:0]            c_reqack,
  output logic [DATA_WIDTH-1:0]           c_resp,
  output logic [TAG_WIDTH-1:0]            c_resptag,
  output logic [N_CLIENTS-1:0]            c_respcyc,
  input  logic [N_CLIENTS-1:0]            c_respack,
  output logic [DATA_WIDTH-1:0]           req,
  output logic [TAG_WIDTH-1:0]            reqtag,
  output logic                            reqcyc,
  input  logic                            reqack,
  input  logic [DATA_WIDTH-1:0]           resp,
  input  logic [TAG_WIDTH-1:0]            resptag,
  input  logic                            respcyc,
  output logic                            respack
);
  localparam int IW = $clog2(N_CLIENTS);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = (RESP_BEATS > 1) ? $clog2(RESP_BEATS) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d, rr_q, rr_d, winner;
  logic                  first_q, first_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [OW-1:0]         outst_q [N_CLIENTS];
  logic [OW-1:0]         outst_d [N_CLIENTS];
  logic [N_CLIENTS-1:0]  elig, respcyc_int;
  logic                  any_elig, grant_cyc, req_fire, inc_read;
  logic [DATA_WIDTH-1:0] sel_req;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [ID_WIDTH-1:0]   resp_id;
  logic                  resp_hit, respack_int, resp_fire, resp_last, resp_underflow;

  // A read is only eligible while its client still has an outstanding-read slot free.
  always_comb begin
    int idx;
    idx      = 0;
    elig     = '0;
    winner   = '0;
    any_elig = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++)
      elig[i] = c_reqcyc[i] && (!c_reqtag[i*TAG_WIDTH + TAG_WIDTH-1] ||
                                outst_q[i] < OW'(MAX_OUTSTANDING));
    for (int k = 0; k < N_CLIENTS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
      if (!any_elig && elig[idx]) begin
        winner   = IW'(idx);
        any_elig = 1'b1;
      end
    end
  end

  assign sel_req   = c_req[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_tag   = c_reqtag[int'(grant_q)*TAG_WIDTH +: TAG_WIDTH];
  assign grant_cyc = c_reqcyc[grant_q];
  assign reqcyc    = (state_q == S_GRANT) && grant_cyc;
  assign req       = sel_req;
  assign req_fire  = reqcyc && reqack;
  assign c_reqack  = req_fire ? (N_CLIENTS'(1) << grant_q) : '0;
  assign inc_read  = req_fire && first_q && sel_tag[TAG_WIDTH-1];

  always_comb begin
    reqtag                 = sel_tag;
    reqtag[ID_WIDTH-1:0]   = ID_WIDTH'(grant_q);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    first_d = first_q;
    case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          state_d = S_GRANT;
          grant_d = winner;
          first_d = 1'b1;
        end
      end
      S_GRANT: begin
        if (!grant_cyc) begin
          state_d = S_IDLE;
          rr_d    = (grant_q == IW'(N_CLIENTS-1)) ? '0 : grant_q + 1'b1;
        end else if (req_fire) begin
          first_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response routing; unknown IDs are acked and dropped so the bus never stalls.
  assign resp_id   = resptag[ID_WIDTH-1:0];
  assign c_resp    = resp;
  assign c_resptag = resptag;

  always_comb begin
    respcyc_int = '0;
    resp_hit    = 1'b0;
    respack_int = respcyc;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (resp_id == ID_WIDTH'(i)) begin
        resp_hit       = 1'b1;
        respcyc_int[i] = respcyc;
        respack_int    = respcyc && c_respack[i];
      end
    end
  end

  assign c_respcyc = reset ? respcyc_int : '0;
  assign respack   = reset && respack_int;
  assign resp_fire = resp_hit && respcyc && respack_int;
  assign resp_last = resp_fire && (beat_q == BW'(RESP_BEATS-1));

  always_comb begin
    beat_d         = beat_q;
    resp_underflow = 1'b0;
    if (resp_fire) beat_d = resp_last ? '0 : beat_q + 1'b1;
    for (int i = 0; i < N_CLIENTS; i++) begin
      outst_d[i] = outst_q[i];
      if (inc_read && grant_q == IW'(i)) outst_d[i] = outst_d[i] + 1'b1;
      if (resp_last && resp_id == ID_WIDTH'(i)) begin
        if (outst_q[i] != '0) outst_d[i] = outst_d[i] - 1'b1;
        else                  resp_underflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      first_q <= 1'b0;
      beat_q  <= '0;
      for (int i = 0; i < N_CLIENTS; i++) outst_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      first_q <= first_d;
      beat_q  <= beat_d;
      for (int i = 0; i < N_CLIENTS; i++) outst_q[i] <= outst_d[i];
    end
  end

  assert property (@(posedge clk) disable iff (!reset) !resp_underflow);

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: behavioural clients and bus model, hand-computed expectations.
module tb_sysbus_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int TW = 13;

  logic            clk, reset;
  logic [N*DW-1:0] c_req;
  logic [N*TW-1:0] c_reqtag;
  logic [N-1:0]    c_reqcyc, c_reqack, c_respcyc, c_respack;
  logic [DW-1:0]   c_resp, req, resp;
  logic [TW-1:0]   c_resptag, reqtag, resptag;
  logic            reqcyc, reqack, respcyc, respack;

  int n_err, n_chk;
  int wcnt, ack_delay;
  int cl_left [N];
  int cl_len [N];
  int cl_bursts [N];
  int ack_cnt [N];
  logic [1:0]    acc_ids [$];
  logic [TW-1:0] acc_tags [$];
  logic [DW-1:0] acc_data [$];

  sysbus_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_reqtag(c_reqtag), .c_reqcyc(c_reqcyc), .c_reqack(c_reqack),
    .c_resp(c_resp), .c_resptag(c_resptag), .c_respcyc(c_respcyc), .c_respack(c_respack),
    .req(req), .reqtag(reqtag), .reqcyc(reqcyc), .reqack(reqack),
    .resp(resp), .resptag(resptag), .respcyc(respcyc), .respack(respack)
  );

  assign reqack = reqcyc && (wcnt >= ack_delay);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample the settled pre-edge bus, step the edge, update client/bus models.
  task automatic tick();
    logic [N-1:0] ack_s;
    logic         fire_s, cyc_s;
    ack_s  = c_reqack & c_reqcyc;
    fire_s = reqcyc && reqack;
    cyc_s  = reqcyc;
    if (fire_s) begin
      acc_ids.push_back(reqtag[1:0]);
      acc_tags.push_back(reqtag);
      acc_data.push_back(req);
    end
    @(posedge clk);
    #1;
    if (fire_s || !cyc_s) wcnt = 0;
    else                  wcnt++;
    for (int i = 0; i < N; i++) begin
      if (ack_s[i]) begin
        ack_cnt[i]++;
        cl_left[i]--;
        if (cl_left[i] == 0) begin
          c_reqcyc[i] = 1'b0;
          cl_bursts[i]--;
        end
      end else if (!c_reqcyc[i] && cl_bursts[i] > 0) begin
        c_reqcyc[i] = 1'b1;
        cl_left[i]  = cl_len[i];
      end
    end
    #1;
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (acc_ids.size() < n && b > 0) begin
      tick();
      b--;
    end
    check(tag, 64'(acc_ids.size()), 64'(n));
  endtask

  task automatic set_client(input int i, input logic [TW-1:0] tag, input int len, input int bursts);
    c_reqtag[i*TW +: TW] = tag;
    c_req[i*DW +: DW]    = 64'hC0DE_0000_0000_0000 + 64'(i);
    cl_len[i]            = len;
    cl_bursts[i]         = bursts;
  endtask

  task automatic send_resp(input logic [1:0] id, input int beats, input bit do_chk);
    logic [N-1:0] exp_oh;
    exp_oh    = N'(1) << id;
    respcyc   = 1'b1;
    c_respack = '1;
    for (int b = 0; b < beats; b++) begin
      resptag = {1'b1, 10'h155, id};
      resp    = 64'hD000 + 64'(b);
      #1;
      if (do_chk) begin
        check("resp_onehot", 64'(c_respcyc), 64'(exp_oh));
        check("respack", 64'(respack), 64'd1);
      end
      tick();
    end
    respcyc = 1'b0;
    #1;
  endtask

  task automatic clear_clients();
    for (int i = 0; i < N; i++) begin
      cl_left[i] = 0; cl_bursts[i] = 0; cl_len[i] = 0; ack_cnt[i] = 0;
    end
    c_reqcyc = '0;
    acc_ids.delete(); acc_tags.delete(); acc_data.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [1:0] exp_ord [6];
    n_err = 0; n_chk = 0; wcnt = 0; ack_delay = 0;
    reset = 1'b0;
    c_req = '0; c_reqtag = '0; c_reqcyc = '0; c_respack = '0;
    resp = '0; resptag = '0; respcyc = 1'b0;
    clear_clients();

    // Reset state, including response path gated while reset is low
    tick(); tick();
    respcyc = 1'b1; resptag = {1'b1, 10'h0, 2'd1}; c_respack = '1;
    #1;
    check("rst_reqcyc", 64'(reqcyc), 0);
    check("rst_c_reqack", 64'(c_reqack), 0);
    check("rst_c_respcyc", 64'(c_respcyc), 0);
    check("rst_respack", 64'(respack), 0);
    for (int i = 0; i < N; i++) check("rst_outst", 64'(dut.outst_q[i]), 0);
    respcyc = 1'b0; c_respack = '0;
    reset = 1'b1;
    tick();

    // Single read from client 1, bus acks after 2 cycles
    ack_delay = 2;
    set_client(1, {1'b1, 10'h2B4, 2'b11}, 1, 1);
    tick();
    check("arb_latency_lo", 64'(reqcyc), 0);
    tick();
    check("arb_latency_hi", 64'(reqcyc), 1);
    check("no_early_ack", 64'(c_reqack), 0);
    wait_acc("t1_accepts", 1, 20);
    check("t1_id", 64'(acc_ids[0]), 1);
    check("t1_tag", 64'(acc_tags[0]), 64'({1'b1, 10'h2B4, 2'b01}));
    tick(); tick(); tick();
    check("t1_ackcnt", 64'(ack_cnt[1]), 1);
    check("t1_outst_inc", 64'(dut.outst_q[1]), 1);

    // 8 response beats to client 1
    send_resp(2'd1, 8, 1'b1);
    check("t2_resp_idle", 64'(c_respcyc), 0);
    check("t2_outst_dec", 64'(dut.outst_q[1]), 0);

    // Round robin among 0,2,3, one-beat writes, two bursts each
    clear_clients();
    pulse_reset();
    ack_delay = 0;
    set_client(0, {1'b0, 10'h011, 2'b10}, 1, 2);
    set_client(2, {1'b0, 10'h022, 2'b01}, 1, 2);
    set_client(3, {1'b0, 10'h033, 2'b00}, 1, 2);
    exp_ord = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    wait_acc("t3_accepts", 6, 200);
    for (int k = 0; k < 6; k++)
      if (k < acc_ids.size()) check("t3_order", 64'(acc_ids[k]), 64'(exp_ord[k]));
    if (acc_data.size() > 1) check("t3_data", acc_data[1], 64'hC0DE_0000_0000_0002);

    // Client 2 4-beat write burst holds the lock against client 0
    clear_clients();
    ack_delay = 1;
    set_client(2, {1'b0, 10'h0F0, 2'b00}, 4, 1);
    tick();
    set_client(0, {1'b0, 10'h00F, 2'b00}, 1, 1);
    wait_acc("t4_accepts", 5, 100);
    for (int k = 0; k < 5; k++)
      if (k < acc_ids.size()) check("t4_lock", 64'(acc_ids[k]), (k < 4) ? 64'd2 : 64'd0);

    // Outstanding limit: third read from client 0 waits for first response to finish
    clear_clients();
    ack_delay = 0;
    set_client(0, {1'b1, 10'h0AA, 2'b00}, 1, 3);
    for (int k = 0; k < 30; k++) tick();
    check("t5_two_accepted", 64'(acc_ids.size()), 2);
    check("t5_outst_full", 64'(dut.outst_q[0]), 2);
    check("t5_stalled", 64'(reqcyc), 0);
    send_resp(2'd0, 7, 1'b0);
    check("t5_still_stalled", 64'(acc_ids.size()), 2);
    send_resp(2'd0, 1, 1'b0);
    wait_acc("t5_third", 3, 20);
    tick(); tick();
    check("t5_outst_refill", 64'(dut.outst_q[0]), 2);

    // Reset asserted mid-burst
    clear_clients();
    set_client(3, {1'b0, 10'h3C3, 2'b00}, 4, 1);
    wait_acc("t6_accepts", 2, 40);
    respcyc = 1'b1; resptag = {1'b1, 10'h0, 2'd0}; c_respack = '1;
    #1;
    check("t6_pre_reqcyc", 64'(reqcyc), 1);
    check("t6_pre_reqack", 64'(c_reqack), 64'h8);
    check("t6_pre_respack", 64'(respack), 1);
    reset = 1'b0;
    #1;
    check("t6_reqcyc", 64'(reqcyc), 0);
    check("t6_c_reqack", 64'(c_reqack), 0);
    check("t6_respack", 64'(respack), 0);
    check("t6_c_respcyc", 64'(c_respcyc), 0);
    clear_clients();
    respcyc = 1'b0;
    tick();
    check("t6_outst0", 64'(dut.outst_q[0]), 0);
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
